// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit built on a per-register countdown scoreboard.
// Stalls ID on unresolved RAW/WAW or a busy multi-cycle ALU and flags forwardable sources.
module hazard_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 4,
    parameter int LAT_W    = 3,
    parameter int MC_W     = 4,
    parameter int FWD_EN   = 1,
    parameter int FWD_WIN  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_wr,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             id_mc_start,
    input  logic [MC_W-1:0]  id_mc_cycles,
    input  logic             flush,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             fwd_rs1,
    output logic             fwd_rs2,
    output logic             mc_busy,
    output logic [15:0]      stall_cnt
);

    // Counter values at or below THR are reachable through the bypass network.
    localparam logic [LAT_W-1:0] THR = (FWD_EN != 0) ? LAT_W'(FWD_WIN) : '0;

    logic [LAT_W-1:0] sb_q [1:NUM_REGS-1];
    logic [LAT_W-1:0] sb_d [1:NUM_REGS-1];
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic [LAT_W-1:0] rs1_sb, rs2_sb, rd_sb;
    logic             pend1, pend2, raw1, raw2, waw;
    logic             stall, issue;

    // Register 0 and indices beyond NUM_REGS read as "always current".
    always_comb begin
        rs1_sb = '0;
        rs2_sb = '0;
        rd_sb  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (id_rs1 == REG_W'(r)) rs1_sb = sb_q[r];
            if (id_rs2 == REG_W'(r)) rs2_sb = sb_q[r];
            if (id_rd  == REG_W'(r)) rd_sb  = sb_q[r];
        end
    end

    always_comb begin
        pend1 = id_rs1_used && (id_rs1 != '0) && (rs1_sb != '0);
        pend2 = id_rs2_used && (id_rs2 != '0) && (rs2_sb != '0);
        raw1  = pend1 && (rs1_sb > THR);
        raw2  = pend2 && (rs2_sb > THR);
        waw   = id_rd_wr && (id_rd != '0) && (rd_sb != '0) && (rd_sb >= id_lat);
        stall = id_valid && !flush && ((mc_cnt_q != '0) || raw1 || raw2 || waw);
        issue = id_valid && !flush && !stall;
    end

    assign if_id_stall = stall;
    assign id_ex_stall = stall;
    assign fwd_rs1     = pend1 && !raw1;
    assign fwd_rs2     = pend2 && !raw2;
    assign mc_busy     = (mc_cnt_q != '0);
    assign stall_cnt   = stall_cnt_q;

    // A fresh load on issue takes priority over the per-cycle countdown.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            sb_d[r] = sb_q[r];
            if (issue && id_rd_wr && (id_rd == REG_W'(r)) && (id_lat != '0)) begin
                sb_d[r] = id_lat;
            end else if (sb_q[r] != '0) begin
                sb_d[r] = sb_q[r] - 1'b1;
            end
        end

        mc_cnt_d = mc_cnt_q;
        if (issue && id_mc_start) begin
            mc_cnt_d = id_mc_cycles;
        end else if (mc_cnt_q != '0) begin
            mc_cnt_d = mc_cnt_q - 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                sb_q[r] <= '0;
            end
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                sb_q[r] <= sb_d[r];
            end
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the decode-stage hazard unit. Instead of comparing ID sources against fixed EX/MEM/WB destination fields, it keeps a per-register countdown scoreboard of in-flight writes. It stalls ID only when a source or destination cannot yet be satisfied, and flags operands that can be forwarded. It also tracks multi-cycle ALU occupancy and counts stall cycles. It sits beside the ID stage and drives the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- NUM_REGS, 16, architectural register count; register 0 is hard-wired zero and never tracked
- REG_W, 4, register index width; must satisfy 2^REG_W >= NUM_REGS
- LAT_W, 3, width of latency and scoreboard counters
- MC_W, 4, width of the multi-cycle busy counter
- FWD_EN, 1, enables forwarding resolution; when 0, every pending source stalls
- FWD_WIN, 2, counter values 1..FWD_WIN are forwardable; requires FWD_WIN < 2^LAT_W

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  REG_W each  source indices
- id_rs1_used, id_rs2_used  in  1 each  the source is actually read
- id_rd  in  REG_W  destination index
- id_rd_wr  in  1  the instruction writes id_rd
- id_lat  in  LAT_W  cycles from issue until id_rd is readable from the register file; 0 means untracked
- id_mc_start  in  1  the instruction occupies the multi-cycle ALU
- id_mc_cycles  in  MC_W  extra occupancy cycles; 0 means none
- flush  in  1  kill the ID instruction this cycle
- if_id_stall  out  1  hold IF/ID
- id_ex_stall  out  1  hold ID/EX input; insert a bubble
- fwd_rs1, fwd_rs2  out  1 each  the source must take a bypass value
- mc_busy  out  1  the multi-cycle unit is occupied
- stall_cnt  out  16  saturating count of stall cycles

## Operation
Scoreboard state:
- sb[r], LAT_W bits, one per register r = 1..NUM_REGS-1.
- Value 0 means the register-file value is current.
- sb[0] is constant 0.

Thresholds and per-source conditions:
- thr = FWD_EN ? FWD_WIN : 0.
- For s in {rs1, rs2}, pend_s = used_s && s != 0 && sb[s] != 0.
- raw_s = pend_s && sb[s] > thr.
- fwd_s = pend_s && sb[s] <= thr && !raw_s.

Write-after-write:
- waw = id_rd_wr && id_rd != 0 && sb[id_rd] != 0 && sb[id_rd] >= id_lat.
- A younger write must complete strictly after the older one.

Stall and issue:
- stall = id_valid && !flush && (mc_busy || raw_rs1 || raw_rs2 || waw).
- if_id_stall = id_ex_stall = stall.
- issue = id_valid && !flush && !stall.

Each cycle, every nonzero sb[r] decrements by 1. On issue:
- If id_rd_wr && id_rd != 0 && id_lat != 0, load sb[id_rd] <= id_lat. The load overrides the decrement.
- If id_mc_start, load mc_cnt <= id_mc_cycles.

Multi-cycle unit:
- mc_busy = (mc_cnt != 0).
- mc_cnt decrements while nonzero, except when a load occurs.

Flush:
- Flush only suppresses the current ID instruction.
- Older in-flight writes keep counting down; the scoreboard is not cleared.

Stall counter:
- stall_cnt increments on each cycle with stall = 1.
- It saturates at 16'hFFFF.

## Timing
- Reset, asynchronous: all sb = 0, mc_cnt = 0, stall_cnt = 0. Hence if_id_stall = id_ex_stall = fwd_rs1 = fwd_rs2 = mc_busy = 0.
- Stall and fwd outputs are combinational from current state and ID inputs, valid in the same cycle.
- Issue at cycle t with id_lat = L: sb[rd] = L in cycle t+1 and reaches 0 in cycle t+1+L.
  - With FWD_EN = 0, a dependent can issue in cycle t+1+L.
  - With FWD_EN = 1, a dependent issues in the first cycle sb <= FWD_WIN, with fwd asserted.
- Issue at t with id_mc_start and id_mc_cycles = N: stall in cycles t+1..t+N; next issue possible at t+N+1.
- id_mc_start is ignored unless issue.
- Simultaneous events:
  - Issue to a register whose counter is decrementing: the load wins.
  - flush with a hazard: no stall, no issue.
  - rs1 == rs2: both fwd flags may assert together.
- Reset asserted mid-operation clears all pending state immediately. The next instruction after release issues without stalls.

## Test plan
- Reset with id_valid = 1, id_rs1 = 3 used: stall = 0, fwd = 0, stall_cnt = 0.
- FWD_EN = 1, FWD_WIN = 2: issue rd = 5, lat = 4 at t, then hold a consumer of r5. Expect stall at t+1, t+2; issue at t+3 with fwd_rs1 = 1. Repeat with FWD_EN = 0: issue at t+5, fwd = 0.
- Issue mc_start with mc_cycles = 3 at t, then a consumer with no register dependence. Expect mc_busy and stall at t+1..t+3, issue at t+4, stall_cnt = 3.
- WAW: issue rd = 7, lat = 4; next cycle present rd = 7, lat = 2. Expect stall until sb[7] < 2, then issue; sb[7] reloads to 2.
- Consumer of r0, or unused source equal to a pending rd: never stalls, fwd = 0. flush during a RAW stall: stall = 0 and sb unchanged except decrement.
- Force 65536+ stall cycles: stall_cnt holds at 16'hFFFF. Assert rst_n = 0 mid-stall: all outputs 0 asynchronously.
